piso_bit_serializer: RTL and testbench
======================================

# piso_bit_serializer

Parallel-in/serial-out stage that feeds the sequence-detector FSMs in this directory. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `data`, which drives the detector's `data` input directly. Back-to-back words stream with no idle gap, so the detector sees a continuous bitstream.

## Interface
- `WIDTH`, 8: bits per parallel word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- `IDLE_LEVEL`, 0: value driven on `data` when no word is being shifted.

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  reset; one clock, reset asynchronous and active-low.
- `din`  in  WIDTH  parallel word; sampled only on handshake.
- `din_valid`  in  1  `din` holds a word.
- `din_ready`  out  1  block can accept a word this cycle.
- `data`  out  1  serial bit to the detector (registered).
- `data_valid`  out  1  `data` carries a payload bit this cycle.
- `busy`  out  1  a word is in the shifter.

## Operation
- Reset (async assert, sync-safe deassert): state IDLE, shift register 0, bit counter 0, `data`=IDLE_LEVEL, `data_valid`=0, `busy`=0, `din_ready`=1.
- States: IDLE, SHIFT.
- IDLE: `din_ready`=1. On `din_valid && din_ready` at a rising edge: load `din` into the shift register, counter <= 0, go to SHIFT.
- SHIFT: `data` = current bit (MSB or LSB per MSB_FIRST), `data_valid`=1, `busy`=1; counter increments each clock.
- `din_ready` = (state==IDLE) || (state==SHIFT && counter==WIDTH-1); combinational from registered state only, never from `din_valid`.
- Last bit (counter==WIDTH-1): if handshake occurs, reload and stay in SHIFT with counter <= 0 (gapless); else go to IDLE.
- `din` is ignored in all cycles without a handshake; a change in `din` mid-word has no effect.
- Counter width = $clog2(WIDTH); it never exceeds WIDTH-1 and does not wrap other than by reload.
- Reset asserted mid-word: word discarded immediately, outputs return to reset values asynchronously; no partial bits after deassertion.

## Timing
- Latency: handshake at edge N -> first bit on `data` during cycle N+1 (after edge N).
- One word occupies exactly WIDTH cycles of `data_valid`=1.
- Streaming throughput: one bit per clock, 100%, when `din_valid` is held high.
- Idle gap: if no word is available at the last-bit edge, `data`=IDLE_LEVEL and `data_valid`=0 from the next cycle until the cycle after the next handshake.
- `data`, `data_valid`, `busy` are register outputs; no combinational path from `din`/`din_valid` to any output.

## Structure
- Shared package `fsm_common_pkg`: state encoding constants (IDLE=1'b0, SHIFT=1'b1), reused by neighbouring FSM blocks.
- Single module; counter and shift register are inline. No sub-module.
- Top-level integration: `piso_bit_serializer.data` -> `moore_non_over.data`, common `clk`/`rstn`.

## Test plan
- Reset: `rstn`=0 with `din_valid`=1 -> `din_ready`=1, `data`=0, `data_valid`=0, `busy`=0; no load while in reset.
- Single word, WIDTH=8, MSB_FIRST=1, `din`=8'b1001_1001 -> `data` = 1,0,0,1,1,0,0,1 over 8 cycles, `data_valid`=1 throughout, then 0; the downstream detector pulses for "1001" as expected.
- Back-to-back: 8'hA5 then 8'h3C with `din_valid` held high -> 16 consecutive `data_valid` cycles, bits 10100101 00111100, `din_ready` high only on bit-7 cycles.
- Gap: second word presented 3 cycles after the first ends -> 3 cycles of `data_valid`=0, `data`=IDLE_LEVEL, then the second word.
- LSB-first: MSB_FIRST=0, `din`=8'h01 -> `data` = 1,0,0,0,0,0,0,0.
- Mid-word reset: assert `rstn`=0 after bit 3 of 8'hFF -> outputs reset immediately; after release, IDLE with `din_ready`=1 and no residual bits.

Source files
------------

// File: rtl/fsm_common_pkg.sv
// State encoding shared by the serializer and the neighbouring sequence-detector FSMs.
package fsm_common_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } fsm_state_t;

endpackage : fsm_common_pkg

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words on a valid/ready handshake and
// streams them one registered bit per clock, gapless when words arrive back-to-back.
module piso_bit_serializer
  import fsm_common_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             data,
  output logic             data_valid,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  fsm_state_t       r_state;
  fsm_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_data;
  logic             r_data_valid;
  logic             r_busy;

  logic             w_last;
  logic             w_load;
  logic             w_advance;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_next_bit;

  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  // Ready depends only on registered state, so din_valid can never loop back into it.
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
  assign din_ready = (r_state == ST_IDLE) || w_last;
  assign w_load    = din_valid && din_ready;

  assign w_shift_nxt = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!w_last)      w_advance   = 1'b1;
        else if (!w_load) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_data       <= IDLE_LEVEL;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else if (w_load) begin
      r_shift      <= din;
      r_cnt        <= '0;
      r_data       <= first_bit(din);
      r_data_valid <= 1'b1;
      r_busy       <= 1'b1;
    end else if (w_advance) begin
      r_shift      <= w_shift_nxt;
      r_cnt        <= r_cnt + CNT_W'(1);
      r_data       <= w_next_bit;
    end else if (w_last) begin
      // Last bit went out with nothing queued behind it: drop to the idle line level.
      r_shift      <= '0;
      r_cnt        <= '0;
      r_data       <= IDLE_LEVEL;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign busy       = r_busy;

endmodule : piso_bit_serializer

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run against a bit-queue reference model, on MSB-first and LSB-first instances.
module tb_piso_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] din_a, din_b;
  logic         vld_a, vld_b;
  logic         rdy_a, rdy_b;
  logic         data_a, data_b;
  logic         dv_a, dv_b;
  logic         busy_a, busy_b;

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rstn(rstn), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .data(data_a), .data_valid(dv_a), .busy(busy_a)
  );

  piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rstn(rstn), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .data(data_b), .data_valid(dv_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic         vld;
    logic [W-1:0] din;
    logic         rdy;
    logic         data;
    logic         dv;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vld, input logic [W-1:0] din,
                     input logic rdy, input logic d, input logic dv, input logic bsy);
    vec_t v;
    v.vld = vld; v.din = din; v.rdy = rdy; v.data = d; v.dv = dv; v.busy = bsy;
    vecs.push_back(v);
  endtask

  // Eight payload cycles; bits lists the expected serial order left to right.
  task automatic add_word(input logic [W-1:0] bits, input logic vld, input logic [W-1:0] din,
                          input logic last_vld, input logic [W-1:0] last_din);
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) add(last_vld, last_din, 1'b1, bits[0], 1'b1, 1'b1);
      else            add(vld, din, 1'b0, bits[W-1-i], 1'b1, 1'b1);
    end
  endtask

  bit qa[$];
  bit qb[$];

  initial begin
    logic hs_a, hs_b;
    logic exp_a, exp_b;

    // Directed table for the MSB-first instance.
    add(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    add_word(8'b1001_1001, 1'b0, 8'hFF, 1'b0, 8'h00);
    add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    add_word(8'b1010_0101, 1'b1, 8'h3C, 1'b1, 8'h3C);
    add_word(8'b0011_1100, 1'b0, 8'h00, 1'b0, 8'h00);
    add(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    add_word(8'b1100_0011, 1'b0, 8'h00, 1'b0, 8'h00);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held with din_valid high: nothing may load.
    rstn = 1'b0;
    vld_a = 1'b1; din_a = 8'hFF;
    vld_b = 1'b1; din_b = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    check("rst rdy_a",  rdy_a,  1'b1);
    check("rst data_a", data_a, 1'b0);
    check("rst dv_a",   dv_a,   1'b0);
    check("rst busy_a", busy_a, 1'b0);
    check("rst rdy_b",  rdy_b,  1'b1);
    check("rst data_b", data_b, 1'b1);
    check("rst dv_b",   dv_b,   1'b0);
    check("rst busy_b", busy_b, 1'b0);
    @(negedge clk);
    rstn = 1'b1; vld_a = 1'b0; vld_b = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      vld_a = vecs[i].vld;
      din_a = vecs[i].din;
      #1;
      check($sformatf("vec%0d rdy", i),  rdy_a,  vecs[i].rdy);
      check($sformatf("vec%0d data", i), data_a, vecs[i].data);
      check($sformatf("vec%0d dv", i),   dv_a,   vecs[i].dv);
      check($sformatf("vec%0d busy", i), busy_a, vecs[i].busy);
    end

    // LSB-first word 8'h01 on the instance whose idle level is 1.
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b1; din_b = 8'h01;
    #1;
    check("lsb idle data", data_b, 1'b1);
    check("lsb idle rdy",  rdy_b,  1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      vld_b = 1'b0; din_b = 8'hFE;
      #1;
      check($sformatf("lsb bit%0d data", i), data_b, (i == 0) ? 1'b1 : 1'b0);
      check($sformatf("lsb bit%0d dv", i),   dv_b,   1'b1);
      check($sformatf("lsb bit%0d rdy", i),  rdy_b,  (i == W - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    #1;
    check("lsb after dv",   dv_b,   1'b0);
    check("lsb after data", data_b, 1'b1);

    // Reset asserted mid-word, while bit 3 of 8'hFF is on the line.
    @(negedge clk);
    vld_a = 1'b1; din_a = 8'hFF;
    @(negedge clk);
    vld_a = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid bit3 data", data_a, 1'b1);
    check("mid bit3 dv",   dv_a,   1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid rst data", data_a, 1'b0);
    check("mid rst dv",   dv_a,   1'b0);
    check("mid rst busy", busy_a, 1'b0);
    check("mid rst rdy",  rdy_a,  1'b1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post rst%0d dv", i),   dv_a,   1'b0);
      check($sformatf("post rst%0d data", i), data_a, 1'b0);
      check($sformatf("post rst%0d busy", i), busy_a, 1'b0);
      check($sformatf("post rst%0d rdy", i),  rdy_a,  1'b1);
    end

    // Randomized traffic against a queue of bits still owed on the line.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      vld_a = ($urandom_range(0, 3) != 0);
      din_a = W'($urandom);
      vld_b = ($urandom_range(0, 3) != 0);
      din_b = W'($urandom);
      #1;
      exp_a = (qa.size() != 0) ? qa[0] : 1'b0;
      exp_b = (qb.size() != 0) ? qb[0] : 1'b1;
      check($sformatf("rnd%0d a rdy", c),  rdy_a,  (qa.size() <= 1));
      check($sformatf("rnd%0d a data", c), data_a, exp_a);
      check($sformatf("rnd%0d a dv", c),   dv_a,   (qa.size() != 0));
      check($sformatf("rnd%0d a busy", c), busy_a, (qa.size() != 0));
      check($sformatf("rnd%0d b rdy", c),  rdy_b,  (qb.size() <= 1));
      check($sformatf("rnd%0d b data", c), data_b, exp_b);
      check($sformatf("rnd%0d b dv", c),   dv_b,   (qb.size() != 0));
      check($sformatf("rnd%0d b busy", c), busy_b, (qb.size() != 0));
      hs_a = vld_a && (qa.size() <= 1);
      hs_b = vld_b && (qb.size() <= 1);
      @(posedge clk);
      if (qa.size() != 0) void'(qa.pop_front());
      if (qb.size() != 0) void'(qb.pop_front());
      if (hs_a) for (int k = 0; k < W; k++) qa.push_back(din_a[W-1-k]);
      if (hs_b) for (int k = 0; k < W; k++) qb.push_back(din_b[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_piso_bit_serializer
